// File: rtl/cmp_pkg.sv
// ----------------------------------------------------------------------------
// cmp_pkg
// Shared definitions for consumers of the 4-bit magnitude comparator.
// Contents:
//   relation_t : 2-bit relation code (UNKNOWN, EQ, GT, LT)
// ----------------------------------------------------------------------------
package cmp_pkg;

    // UNKNOWN is deliberately the all-zero code so a reset register reads it.
    typedef enum logic [1:0] {
        REL_UNKNOWN = 2'b00,
        REL_EQ      = 2'b01,
        REL_GT      = 2'b10,
        REL_LT      = 2'b11
    } relation_t;

endpackage

// File: rtl/cmp_flag_decode.sv
// ----------------------------------------------------------------------------
// cmp_flag_decode
// Purely combinational decode of the comparator flag triple into a relation
// candidate. Any triple that is not exactly one-hot is flagged as illegal.
// Ports:
//   equal, greater, lesser : in  comparator flags
//   candidate              : out decoded relation (UNKNOWN when illegal)
//   illegal                : out high when the triple is not one-hot
// ----------------------------------------------------------------------------
module cmp_flag_decode
    import cmp_pkg::*;
(
    input  logic      equal,
    input  logic      greater,
    input  logic      lesser,
    output relation_t candidate,
    output logic      illegal
);

    // Only the three one-hot patterns map to a relation; 000 and any
    // multi-bit pattern fall through to the illegal default.
    always_comb begin
        candidate = REL_UNKNOWN;
        illegal   = 1'b0;
        case ({equal, greater, lesser})
            3'b100:  candidate = REL_EQ;
            3'b010:  candidate = REL_GT;
            3'b001:  candidate = REL_LT;
            default: illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/cmp_result_filter.sv
// ----------------------------------------------------------------------------
// cmp_result_filter
// Debounces comparator flags into a stable registered relation. A relation is
// adopted only after STABLE_CNT consecutive agreeing valid samples. Counts
// changes between known relations, pulses on every change and keeps a sticky
// error for non-one-hot samples.
// Parameters:
//   STABLE_CNT : agreeing samples needed to adopt a relation (1..15)
//   CHG_W      : width of the saturating change counter
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   in_valid                : sample strobe
//   equal, greater, lesser  : comparator flags
//   err_clr                 : clears flag_error
//   state                   : stable relation (00 UNK, 01 EQ, 10 GT, 11 LT)
//   state_valid             : high once state has left UNKNOWN
//   change_pulse            : one-cycle pulse on every state change
//   change_count            : saturating count of known-to-known changes
//   flag_error              : sticky non-one-hot indicator
// ----------------------------------------------------------------------------
module cmp_result_filter
    import cmp_pkg::*;
#(
    parameter int STABLE_CNT = 3,
    parameter int CHG_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             equal,
    input  logic             greater,
    input  logic             lesser,
    input  logic             err_clr,
    output logic [1:0]       state,
    output logic             state_valid,
    output logic             change_pulse,
    output logic [CHG_W-1:0] change_count,
    output logic             flag_error
);

    localparam int               RUN_W   = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
    localparam logic [CHG_W-1:0] CHG_MAX = '1;

    relation_t        candidate;
    logic             illegal;
    relation_t        prev_cand;
    relation_t        state_q;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_next;
    logic             adopt;

    cmp_flag_decode u_decode (
        .equal     (equal),
        .greater   (greater),
        .lesser    (lesser),
        .candidate (candidate),
        .illegal   (illegal)
    );

    // Next run length for the current sample and whether it completes a run
    // for a relation different from the one already held. A candidate equal
    // to the held state still extends its run but never adopts.
    always_comb begin
        run_next = run_q;
        adopt    = 1'b0;
        if (illegal) begin
            run_next = '0;
        end else if (candidate == prev_cand) begin
            run_next = (run_q == RUN_MAX) ? run_q : run_q + 1'b1;
        end else begin
            run_next = RUN_W'(1);
        end
        adopt = in_valid && !illegal && (run_next == RUN_MAX) &&
                (candidate != state_q);
    end

    // All state lives here. Nothing moves while in_valid is low except the
    // pulse self-clearing and err_clr. An illegal sample written after the
    // clear lets a same-edge set win over err_clr. The first adoption out of
    // UNKNOWN pulses but is not counted as a change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REL_UNKNOWN;
            prev_cand    <= REL_UNKNOWN;
            run_q        <= '0;
            state_valid  <= 1'b0;
            change_pulse <= 1'b0;
            change_count <= '0;
            flag_error   <= 1'b0;
        end else begin
            change_pulse <= 1'b0;
            if (err_clr) begin
                flag_error <= 1'b0;
            end
            if (in_valid) begin
                run_q <= run_next;
                if (illegal) begin
                    flag_error <= 1'b1;
                    prev_cand  <= REL_UNKNOWN;
                end else begin
                    prev_cand <= candidate;
                end
                if (adopt) begin
                    state_q      <= candidate;
                    change_pulse <= 1'b1;
                    state_valid  <= 1'b1;
                    if (state_q != REL_UNKNOWN && change_count != CHG_MAX) begin
                        change_count <= change_count + 1'b1;
                    end
                end
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_cmp_result_filter.sv
// ----------------------------------------------------------------------------
// tb_cmp_result_filter
// Drives three filter instances from shared inputs:
//   dut 0 : defaults (STABLE_CNT=3, CHG_W=8)
//   dut 1 : CHG_W=2 for change-counter saturation
//   dut 2 : STABLE_CNT=1 for immediate adoption
// Each applied step names the instance whose outputs it expects.
// ----------------------------------------------------------------------------
module tb_cmp_result_filter;

    localparam logic [2:0] EQF = 3'b100;
    localparam logic [2:0] GTF = 3'b010;
    localparam logic [2:0] LTF = 3'b001;
    localparam logic [2:0] NOF = 3'b000;
    localparam logic [2:0] BAD = 3'b110;

    typedef struct {
        string      tag;
        int         dut;
        logic       rst_before;
        logic       vld;
        logic [2:0] flags;
        logic       clr;
        logic [1:0] st;
        logic       sv;
        logic       pulse;
        logic [7:0] cnt;
        logic       err;
    } vec_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic equal;
    logic greater;
    logic lesser;
    logic err_clr;

    logic [1:0] state0, state1, state2;
    logic       sv0, sv1, sv2;
    logic       pulse0, pulse1, pulse2;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [7:0] cnt2;
    logic       err0, err1, err2;

    vec_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    cmp_result_filter #(.STABLE_CNT(3), .CHG_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .equal(equal),
        .greater(greater), .lesser(lesser), .err_clr(err_clr),
        .state(state0), .state_valid(sv0), .change_pulse(pulse0),
        .change_count(cnt0), .flag_error(err0)
    );

    cmp_result_filter #(.STABLE_CNT(3), .CHG_W(2)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .equal(equal),
        .greater(greater), .lesser(lesser), .err_clr(err_clr),
        .state(state1), .state_valid(sv1), .change_pulse(pulse1),
        .change_count(cnt1), .flag_error(err1)
    );

    cmp_result_filter #(.STABLE_CNT(1), .CHG_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .equal(equal),
        .greater(greater), .lesser(lesser), .err_clr(err_clr),
        .state(state2), .state_valid(sv2), .change_pulse(pulse2),
        .change_count(cnt2), .flag_error(err2)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input string tag, input int dut,
                                input logic rb, input logic vld,
                                input logic [2:0] fl, input logic clr,
                                input logic [1:0] st, input logic sv,
                                input logic p, input int cnt,
                                input logic er);
        vec_t v;
        v.tag = tag; v.dut = dut; v.rst_before = rb; v.vld = vld;
        v.flags = fl; v.clr = clr; v.st = st; v.sv = sv; v.pulse = p;
        v.cnt = 8'(cnt); v.err = er;
        return v;
    endfunction

    // One comparison: count it, and report it when it differs.
    task automatic checkField(input string name, input logic [7:0] act,
                              input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the chosen instance.
    task automatic checkOutput(input int dut);
        vec_t       e;
        logic [1:0] st;
        logic       sv, p, er;
        logic [7:0] c;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected entry");
            return;
        end
        e = sb.pop_front();
        case (dut)
            0:       begin st = state0; sv = sv0; p = pulse0; c = cnt0;            er = err0; end
            1:       begin st = state1; sv = sv1; p = pulse1; c = {6'b0, cnt1};   er = err1; end
            default: begin st = state2; sv = sv2; p = pulse2; c = cnt2;            er = err2; end
        endcase
        checkField($sformatf("%s.d%0d.state", e.tag, dut), 8'(st), 8'(e.st));
        checkField($sformatf("%s.d%0d.state_valid", e.tag, dut), 8'(sv), 8'(e.sv));
        checkField($sformatf("%s.d%0d.change_pulse", e.tag, dut), 8'(p), 8'(e.pulse));
        checkField($sformatf("%s.d%0d.change_count", e.tag, dut), c, e.cnt);
        checkField($sformatf("%s.d%0d.flag_error", e.tag, dut), 8'(er), 8'(e.err));
    endtask

    // Drive one sample, queue its expectation, then check after the edge.
    task automatic applyStimulus(input vec_t v);
        in_valid = v.vld;
        {equal, greater, lesser} = v.flags;
        err_clr = v.clr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(v.dut);
    endtask

    // Reset all instances and confirm every one reads its reset state.
    task automatic doReset();
        in_valid = 1'b0;
        {equal, greater, lesser} = NOF;
        err_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sb.push_back(mk("reset", d, 0, 0, NOF, 0, 2'b00, 0, 0, 0, 0));
            checkOutput(d);
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        {equal, greater, lesser} = NOF;
        err_clr = 1'b0;
        #2;

        // Main table: settle, debounce rejection, illegal flags, err_clr
        // priority and valid gaps on dut 0, then STABLE_CNT=1 on dut 2.
        tbl.push_back(mk("settle1",   0, 1, 1, EQF, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk("settle2",   0, 0, 1, EQF, 0, 2'b00, 0, 0, 0, 0));
        tbl.push_back(mk("settle3",   0, 0, 1, EQF, 0, 2'b01, 1, 1, 0, 0));
        tbl.push_back(mk("rej_gt1",   0, 0, 1, GTF, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk("rej_gt2",   0, 0, 1, GTF, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk("rej_eq",    0, 0, 1, EQF, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk("rej_gt3",   0, 0, 1, GTF, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk("rej_gt4",   0, 0, 1, GTF, 0, 2'b01, 1, 0, 0, 0));
        tbl.push_back(mk("adopt_gt",  0, 0, 1, GTF, 0, 2'b10, 1, 1, 1, 0));
        tbl.push_back(mk("run_lt1",   0, 0, 1, LTF, 0, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk("ill_110",   0, 0, 1, BAD, 0, 2'b10, 1, 0, 1, 1));
        tbl.push_back(mk("rst_lt1",   0, 0, 1, LTF, 0, 2'b10, 1, 0, 1, 1));
        tbl.push_back(mk("rst_lt2",   0, 0, 1, LTF, 0, 2'b10, 1, 0, 1, 1));
        tbl.push_back(mk("rst_lt3",   0, 0, 1, LTF, 0, 2'b11, 1, 1, 2, 1));
        tbl.push_back(mk("clr_alone", 0, 0, 0, LTF, 1, 2'b11, 1, 0, 2, 0));
        tbl.push_back(mk("clr_v_000", 0, 0, 1, NOF, 1, 2'b11, 1, 0, 2, 1));
        tbl.push_back(mk("clr_again", 0, 0, 0, NOF, 1, 2'b11, 1, 0, 2, 0));
        tbl.push_back(mk("gap_eq1",   0, 0, 1, EQF, 0, 2'b11, 1, 0, 2, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk("gap_idle", 0, 0, 0, NOF, 0, 2'b11, 1, 0, 2, 0));
        tbl.push_back(mk("gap_eq2",   0, 0, 1, EQF, 0, 2'b11, 1, 0, 2, 0));
        tbl.push_back(mk("gap_idle2", 0, 0, 0, NOF, 0, 2'b11, 1, 0, 2, 0));
        tbl.push_back(mk("gap_eq3",   0, 0, 1, EQF, 0, 2'b01, 1, 1, 3, 0));
        tbl.push_back(mk("gap_after", 0, 0, 0, NOF, 0, 2'b01, 1, 0, 3, 0));
        tbl.push_back(mk("s1_eq",     2, 1, 1, EQF, 0, 2'b01, 1, 1, 0, 0));
        tbl.push_back(mk("s1_gt",     2, 0, 1, GTF, 0, 2'b10, 1, 1, 1, 0));
        tbl.push_back(mk("s1_gt_hold",2, 0, 1, GTF, 0, 2'b10, 1, 0, 1, 0));
        tbl.push_back(mk("s1_000",    2, 0, 1, NOF, 0, 2'b10, 1, 0, 1, 1));
        tbl.push_back(mk("s1_lt",     2, 0, 1, LTF, 0, 2'b11, 1, 1, 2, 1));
        tbl.push_back(mk("s1_idle",   2, 0, 0, EQF, 0, 2'b11, 1, 0, 2, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst_before) doReset();
            applyStimulus(tbl[i]);
        end

        // Asynchronous reset between edges while GT is held and the change
        // pulse for it is still high; then EQ must rebuild from scratch.
        doReset();
        applyStimulus(mk("ar_gt1", 0, 0, 1, GTF, 0, 2'b00, 0, 0, 0, 0));
        applyStimulus(mk("ar_gt2", 0, 0, 1, GTF, 0, 2'b00, 0, 0, 0, 0));
        applyStimulus(mk("ar_gt3", 0, 0, 1, GTF, 0, 2'b10, 1, 1, 0, 0));
        {equal, greater, lesser} = EQF;
        #1;
        rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            sb.push_back(mk("ar_mid", d, 0, 1, EQF, 0, 2'b00, 0, 0, 0, 0));
            checkOutput(d);
        end
        #1;
        rst = 1'b0;
        applyStimulus(mk("ar_eq1", 0, 0, 1, EQF, 0, 2'b00, 0, 0, 0, 0));
        applyStimulus(mk("ar_eq2", 0, 0, 1, EQF, 0, 2'b00, 0, 0, 0, 0));
        applyStimulus(mk("ar_eq3", 0, 0, 1, EQF, 0, 2'b01, 1, 1, 0, 0));

        // Saturation on the 2-bit counter: six alternating GT/LT groups
        // give five known-to-known changes, counter must stop at 3.
        doReset();
        for (int g = 0; g < 6; g++) begin
            for (int k = 0; k < 3; k++) begin
                logic [1:0] new_rel, old_rel;
                int         after_cnt, before_cnt;
                new_rel    = (g % 2 == 0) ? 2'b10 : 2'b11;
                old_rel    = (g == 0) ? 2'b00 : ((g % 2 == 0) ? 2'b11 : 2'b10);
                after_cnt  = (g > 3) ? 3 : g;
                before_cnt = (g == 0) ? 0 : (((g - 1) > 3) ? 3 : g - 1);
                applyStimulus(mk($sformatf("sat_g%0d_k%0d", g, k), 1, 0, 1,
                                 (g % 2 == 0) ? GTF : LTF, 0,
                                 (k == 2) ? new_rel : old_rel,
                                 (g > 0) || (k == 2), k == 2,
                                 (k == 2) ? after_cnt : before_cnt, 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_result_filter.md
# cmp_result_filter

Downstream stage for the 4-bit magnitude comparator. It samples the comparator's `equal`/`greater`/`lesser` flags on a valid strobe and debounces them into a stable registered relation. That relation changes only after `STABLE_CNT` consecutive agreeing samples. The block also counts relation changes, emits a one-cycle change pulse, and raises a sticky error when the flag triple is not one-hot.

## Interface
Parameters:
- `STABLE_CNT`, default 3: consecutive agreeing valid samples required to adopt a relation; legal range 1..15.
- `CHG_W`, default 8: width of the saturating change counter.

Ports:
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  flags are sampled on an edge where this is high.
- `equal`  in  1  comparator flag, a == b.
- `greater`  in  1  comparator flag, a > b.
- `lesser`  in  1  comparator flag, a < b.
- `err_clr`  in  1  clears `flag_error`.
- `state`  out  2  stable relation: 00 UNKNOWN, 01 EQ, 10 GT, 11 LT.
- `state_valid`  out  1  high once `state` has left UNKNOWN.
- `change_pulse`  out  1  one-cycle pulse when `state` changes.
- `change_count`  out  CHG_W  number of EQ/GT/LT-to-different-relation changes, saturating.
- `flag_error`  out  1  sticky flag for a non-one-hot sample.

## Operation
- Decode runs on each `in_valid` edge. A flag triple with exactly one bit set gives candidate EQ, GT or LT. Any other triple (000, or two or more bits set) is illegal.
- Illegal sample:
  - `flag_error` is set.
  - The run counter is cleared to 0 and the previous candidate becomes UNKNOWN.
  - `state` is held.
- Legal sample:
  - If the candidate equals the previous candidate, the run counter increments, saturating at `STABLE_CNT`.
  - Otherwise the run counter loads 1 and the previous candidate is updated.
- Adoption: when the run counter value after update equals `STABLE_CNT` and the candidate differs from `state`:
  - `state` takes the candidate.
  - `change_pulse` is 1 for exactly that cycle.
- First adoption from UNKNOWN:
  - `state_valid` goes high.
  - `change_pulse` asserts.
  - `change_count` does not increment. Only changes between two known relations are counted.
- `change_count` saturates at 2^CHG_W−1 and never wraps.
- Once `state_valid` is high it stays high until reset. `state` never returns to UNKNOWN except on reset.
- When `in_valid` is low, all counters and state hold. There is no timeout or decay.
- `err_clr` clears `flag_error`. If `err_clr` and an illegal sample occur on the same edge, set wins.
- A candidate that matches the current `state` keeps building its run, but produces no pulse and no count.

## Timing
- Reset values:
  - `state`=00, `state_valid`=0, `change_pulse`=0, `change_count`=0, `flag_error`=0.
  - Run counter=0, previous candidate=UNKNOWN.
- All outputs are registered; there are no combinational input-to-output paths.
- Adoption latency: with `in_valid` held high and constant legal flags from edge 1, `state` changes after edge `STABLE_CNT`. `change_pulse` is high in the cycle following that edge.
- With `STABLE_CNT`=1, every legal sample that differs from `state` is adopted on its own edge.
- A gap in `in_valid` does not break a run: agreeing samples need not be on adjacent cycles.
- Reset asserted mid-run asynchronously returns every register to its reset value, including any pulse in flight.

## Structure
- Shared package `cmp_pkg`:
  - 2-bit relation constants REL_UNKNOWN=00, REL_EQ=01, REL_GT=10, REL_LT=11.
  - A relation typedef.
- Sub-module `cmp_flag_decode`: purely combinational. It takes the flag triple and produces the relation candidate plus an `illegal` bit, and is reusable by other comparator consumers.
- The top level holds:
  - the run counter, width ceil(log2(STABLE_CNT+1));
  - the previous-candidate register;
  - the state register;
  - the change counter;
  - the sticky error.

## Test plan
- Reset then settle: reset, then `in_valid`=1 with flags 100 (EQ) for 3 cycles → `state`=01, `state_valid`=1 after the 3rd edge; one `change_pulse`; `change_count`=0.
- Debounce reject: from EQ, apply GT,GT,EQ,GT,GT → `state` stays 01, no pulse. Follow with a 3rd consecutive GT → `state`=10, pulse, `change_count`=1.
- Illegal flags: flags 110 in mid-run → `flag_error`=1, run restarts, `state` held.
  - `err_clr` alone → `flag_error`=0.
  - `err_clr` in the same cycle as a 000 sample → `flag_error` stays 1.
- Valid gaps: LT, `in_valid`=0 for 5 cycles, LT, idle, LT → adopted to 11 on the 3rd valid LT.
- Saturation: with CHG_W=2, alternate GT×3/LT×3 for 5 changes → `change_count` stops at 3.
- Async reset mid-operation: assert `rst` between edges while `state`=GT and a run is in progress → all outputs are 0 immediately. The next 2 EQ samples do not adopt; the 3rd does.
